// File: rtl/test_status_monitor.sv
// test_status_monitor: reduces an rv32i test run to pass/fail/timeout status.
// Ports: clk/rst; start re-arms; is_ecall+gp_value and store_* (tohost) are the
//   termination events; done/done_pulse/pass/fail/timeout/fail_code/cycle_count
//   are all registered or decoded from registered state only.
module test_status_monitor #(
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter bit          USE_TOHOST     = 1'b1,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_ecall,
  input  logic [31:0]      gp_value,
  input  logic             store_valid,
  input  logic [31:0]      store_addr,
  input  logic [31:0]      store_data,
  output logic             done,
  output logic             done_pulse,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [30:0]      fail_code,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  // Count value on the last allowed RUN cycle; only meaningful when the
  // timeout is enabled (TIMEOUT_CYCLES != 0).
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [30:0]      code_q, code_d;
  logic             pulse_q, pulse_d;

  logic tohost_hit;
  logic timeout_hit;

  // A tohost store of 0 is not a verdict; it is ignored.
  assign tohost_hit  = USE_TOHOST && store_valid &&
                       (store_addr == TOHOST_ADDR) && (store_data != 32'd0);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          code_d  = '0;
        end
      end
      S_RUN: begin
        // Priority: restart > ecall > tohost > timeout > count.
        if (start) begin
          cnt_d  = '0;
          code_d = '0;
        end else if (is_ecall) begin
          if (gp_value == 32'd1) begin
            state_d = S_PASS;
          end else begin
            state_d = S_FAIL;
            code_d  = gp_value[31:1];
          end
        end else if (tohost_hit) begin
          if (store_data == 32'd1) begin
            state_d = S_PASS;
          end else begin
            state_d = S_FAIL;
            code_d  = store_data[31:1];
          end
        end else if (timeout_hit) begin
          state_d = S_TIMEOUT;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        // Terminal states hold everything until re-armed.
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          code_d  = '0;
        end
      end
    endcase
  end

  // Pulse only on the RUN -> terminal transition.
  assign pulse_d = (state_q == S_RUN) &&
                   ((state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      pulse_q <= pulse_d;
    end
  end

  assign pass        = (state_q == S_PASS);
  assign fail        = (state_q == S_FAIL);
  assign timeout     = (state_q == S_TIMEOUT);
  assign done        = pass | fail | timeout;
  assign done_pulse  = pulse_q;
  assign fail_code   = code_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_test_status_monitor.sv
module tb_test_status_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_ecall;
  logic [31:0] gp_value;
  logic        store_valid;
  logic [31:0] store_addr;
  logic [31:0] store_data;
  logic        done, done_pulse, pass, fail, timeout;
  logic [30:0] fail_code;
  logic [31:0] cycle_count;

  int n_vec = 0;
  int n_err = 0;

  test_status_monitor #(
    .TIMEOUT_CYCLES(50),
    .TOHOST_ADDR   (32'h0000_1000),
    .USE_TOHOST    (1'b1),
    .CNT_W         (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_ecall   (is_ecall),
    .gp_value   (gp_value),
    .store_valid(store_valid),
    .store_addr (store_addr),
    .store_data (store_data),
    .done       (done),
    .done_pulse (done_pulse),
    .pass       (pass),
    .fail       (fail),
    .timeout    (timeout),
    .fail_code  (fail_code),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are read 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start       = 1'b0;
    is_ecall    = 1'b0;
    gp_value    = 32'd0;
    store_valid = 1'b0;
    store_addr  = 32'd0;
    store_data  = 32'd0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({done, done_pulse, pass, fail, timeout} !== 5'b0 || fail_code !== 31'd0 || cycle_count !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outputs: st=%b code=%0d cnt=%0d, want all zero",
               {done, done_pulse, pass, fail, timeout}, fail_code, cycle_count);
    end
    rst = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (done !== 1'b0 || cycle_count !== 32'd0) begin
      n_err++;
      $display("FAIL idle_hold: done=%b cnt=%0d, want 0/0", done, cycle_count);
    end
  endtask

  task automatic test_ecall_pass();
    do_start();
    repeat (20) tick();
    n_vec++;
    if (done !== 1'b0 || cycle_count !== 32'd20) begin
      n_err++;
      $display("FAIL pass_pre: done=%b cnt=%0d, want 0/20", done, cycle_count);
    end
    is_ecall = 1'b1; gp_value = 32'd1;
    tick();
    is_ecall = 1'b0; gp_value = 32'd0;
    n_vec++;
    if ({done, done_pulse, pass, fail, timeout} !== 5'b11100 || fail_code !== 31'd0 || cycle_count !== 32'd20) begin
      n_err++;
      $display("FAIL ecall_pass: st=%b code=%0d cnt=%0d, want 11100/0/20",
               {done, done_pulse, pass, fail, timeout}, fail_code, cycle_count);
    end
    tick();
    n_vec++;
    if ({done, done_pulse, pass} !== 3'b101 || cycle_count !== 32'd20) begin
      n_err++;
      $display("FAIL pulse_one_cycle: d/dp/p=%b cnt=%0d, want 101/20", {done, done_pulse, pass}, cycle_count);
    end
  endtask

  task automatic test_ecall_fail();
    do_start();
    n_vec++;
    if ({done, pass, fail, timeout} !== 4'b0 || cycle_count !== 32'd0) begin
      n_err++;
      $display("FAIL restart_from_pass: st=%b cnt=%0d, want 0000/0", {done, pass, fail, timeout}, cycle_count);
    end
    repeat (7) tick();
    is_ecall = 1'b1; gp_value = 32'h0000_0007;
    tick();
    is_ecall = 1'b0;
    n_vec++;
    if ({done, done_pulse, pass, fail, timeout} !== 5'b11010 || fail_code !== 31'd3 || cycle_count !== 32'd7) begin
      n_err++;
      $display("FAIL ecall_fail: st=%b code=%0d cnt=%0d, want 11010/3/7",
               {done, done_pulse, pass, fail, timeout}, fail_code, cycle_count);
    end
    // Even gp value 0 still fails, code 0.
    do_start();
    is_ecall = 1'b1; gp_value = 32'd0;
    tick();
    is_ecall = 1'b0;
    n_vec++;
    if ({pass, fail} !== 2'b01 || fail_code !== 31'd0 || cycle_count !== 32'd0) begin
      n_err++;
      $display("FAIL ecall_gp0: p/f=%b code=%0d cnt=%0d, want 01/0/0", {pass, fail}, fail_code, cycle_count);
    end
  endtask

  task automatic test_tohost();
    do_start();
    store_valid = 1'b1; store_addr = 32'h1000; store_data = 32'd0;
    tick();
    n_vec++;
    if (done !== 1'b0 || cycle_count !== 32'd1) begin
      n_err++;
      $display("FAIL tohost_zero: done=%b cnt=%0d, want 0/1", done, cycle_count);
    end
    store_addr = 32'h1004; store_data = 32'd1;
    tick();
    n_vec++;
    if (done !== 1'b0 || cycle_count !== 32'd2) begin
      n_err++;
      $display("FAIL tohost_wrong_addr: done=%b cnt=%0d, want 0/2", done, cycle_count);
    end
    store_addr = 32'h1000; store_data = 32'h0000_000B;
    tick();
    idle_inputs();
    n_vec++;
    if ({done, pass, fail, timeout} !== 4'b1010 || fail_code !== 31'd5 || cycle_count !== 32'd2) begin
      n_err++;
      $display("FAIL tohost_fail: st=%b code=%0d cnt=%0d, want 1010/5/2",
               {done, pass, fail, timeout}, fail_code, cycle_count);
    end
  endtask

  task automatic test_timeout();
    do_start();
    repeat (49) tick();
    n_vec++;
    if (done !== 1'b0 || cycle_count !== 32'd49) begin
      n_err++;
      $display("FAIL timeout_pre: done=%b cnt=%0d, want 0/49", done, cycle_count);
    end
    tick();
    n_vec++;
    if ({done, done_pulse, pass, fail, timeout} !== 5'b11001 || fail_code !== 31'd0 || cycle_count !== 32'd49) begin
      n_err++;
      $display("FAIL timeout_hit: st=%b code=%0d cnt=%0d, want 11001/0/49",
               {done, done_pulse, pass, fail, timeout}, fail_code, cycle_count);
    end
    // Ecall on the threshold edge wins over timeout.
    do_start();
    repeat (49) tick();
    is_ecall = 1'b1; gp_value = 32'd1;
    tick();
    idle_inputs();
    n_vec++;
    if ({done, pass, fail, timeout} !== 4'b1100 || cycle_count !== 32'd49) begin
      n_err++;
      $display("FAIL threshold_ecall: st=%b cnt=%0d, want 1100/49", {done, pass, fail, timeout}, cycle_count);
    end
  endtask

  task automatic test_priority_sticky();
    do_start();
    repeat (3) tick();
    // Restart while running clears the count.
    do_start();
    n_vec++;
    if (done !== 1'b0 || cycle_count !== 32'd0) begin
      n_err++;
      $display("FAIL run_restart: done=%b cnt=%0d, want 0/0", done, cycle_count);
    end
    tick();
    is_ecall = 1'b1; gp_value = 32'd1;
    store_valid = 1'b1; store_addr = 32'h1000; store_data = 32'd5;
    tick();
    idle_inputs();
    n_vec++;
    if ({pass, fail} !== 2'b10 || fail_code !== 31'd0 || cycle_count !== 32'd1) begin
      n_err++;
      $display("FAIL ecall_beats_tohost: p/f=%b code=%0d cnt=%0d, want 10/0/1", {pass, fail}, fail_code, cycle_count);
    end
    is_ecall = 1'b1; gp_value = 32'd9;
    tick();
    is_ecall = 1'b0;
    tick();
    n_vec++;
    if ({done, done_pulse, pass, fail, timeout} !== 5'b10100 || fail_code !== 31'd0 || cycle_count !== 32'd1) begin
      n_err++;
      $display("FAIL sticky_pass: st=%b code=%0d cnt=%0d, want 10100/0/1",
               {done, done_pulse, pass, fail, timeout}, fail_code, cycle_count);
    end
    do_start();
    n_vec++;
    if ({done, done_pulse, pass, fail, timeout} !== 5'b0 || cycle_count !== 32'd0) begin
      n_err++;
      $display("FAIL rearm_clear: st=%b cnt=%0d, want 00000/0", {done, done_pulse, pass, fail, timeout}, cycle_count);
    end
    tick();
    n_vec++;
    if (cycle_count !== 32'd1) begin
      n_err++;
      $display("FAIL rearm_count: cnt=%0d, want 1", cycle_count);
    end
  endtask

  task automatic test_async_reset();
    do_start();
    repeat (5) tick();
    store_valid = 1'b1; store_addr = 32'h1000; store_data = 32'd3;
    tick();
    idle_inputs();
    n_vec++;
    if ({fail, fail_code} !== {1'b1, 31'd1}) begin
      n_err++;
      $display("FAIL pre_reset_fail: fail=%b code=%0d, want 1/1", fail, fail_code);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({done, done_pulse, pass, fail, timeout} !== 5'b0 || fail_code !== 31'd0 || cycle_count !== 32'd0) begin
      n_err++;
      $display("FAIL async_reset: st=%b code=%0d cnt=%0d, want all zero",
               {done, done_pulse, pass, fail, timeout}, fail_code, cycle_count);
    end
    tick();
    rst = 1'b0;
    is_ecall = 1'b1; gp_value = 32'd1;
    tick();
    tick();
    idle_inputs();
    n_vec++;
    if ({done, pass, fail} !== 3'b0 || cycle_count !== 32'd0) begin
      n_err++;
      $display("FAIL idle_ecall_ignored: d/p/f=%b cnt=%0d, want 000/0", {done, pass, fail}, cycle_count);
    end
  endtask

  initial begin
    test_reset();
    test_ecall_pass();
    test_ecall_fail();
    test_tohost();
    test_timeout();
    test_priority_sticky();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/test_status_monitor.md
Name: test_status_monitor

Overview:
- Synthesizable pass/fail/timeout monitor that sits directly downstream of rv32i_core.
- Watches the core's ecall indication, the gp register value (x3), and data-memory stores to a tohost address.
- Reduces a test run to registered status flags and a failure code, which the simulation bench and any FPGA status LEDs consume.
- Follows the riscv-tests convention: gp==1 means pass; gp==(testnum<<1)|1 means fail.

Parameters:
- TIMEOUT_CYCLES, 5000: cycles in RUN before a timeout is declared; 0 disables the timeout.
- TOHOST_ADDR, 32'h0000_1000: store address that is treated as a tohost write.
- USE_TOHOST, 1: 1 enables tohost store detection; 0 ignores the store_* inputs.
- CNT_W, 32: width of cycle_count.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; arms or re-arms the monitor.
- is_ecall  in  1  core is executing ECALL this cycle.
- gp_value  in  32  current regfile x3 value.
- store_valid  in  1  core data-memory write this cycle.
- store_addr  in  32  byte address of the write.
- store_data  in  32  write data.
- done  out  1  level; test has reached a terminal state.
- done_pulse  out  1  one-cycle pulse on entry to any terminal state.
- pass  out  1  level; terminal state is PASS.
- fail  out  1  level; terminal state is FAIL.
- timeout  out  1  level; terminal state is TIMEOUT.
- fail_code  out  31  failing test number (value>>1); 0 unless fail.
- cycle_count  out  CNT_W  cycles spent in RUN, frozen at termination.

Behaviour:
- Reset (async, rst=1): state=IDLE; every output 0, including cycle_count and fail_code. After rst deasserts, the monitor stays in IDLE until start.
- States: IDLE, RUN, PASS, FAIL, TIMEOUT. All outputs are registered and decoded from state/registers; there is no combinational input-to-output path.
- IDLE:
  - is_ecall and store events are ignored.
  - start=1 -> RUN; cycle_count<=0, fail_code<=0.
- RUN, evaluated every rising edge in this priority order:
  1. start=1 -> stay in RUN, clear cycle_count and fail_code (restart); events this cycle are ignored.
  2. is_ecall=1: gp_value==1 -> PASS; otherwise -> FAIL with fail_code<=gp_value[31:1]. If gp_value is even and !=1, still FAIL; fail_code=gp_value[31:1] (may be 0).
  3. USE_TOHOST && store_valid && store_addr==TOHOST_ADDR && store_data!=0: data==1 -> PASS; otherwise -> FAIL with fail_code<=store_data[31:1]. A tohost store with data 0 is ignored.
  4. TIMEOUT_CYCLES!=0 && cycle_count==TIMEOUT_CYCLES-1 -> TIMEOUT.
  5. Otherwise cycle_count<=cycle_count+1, saturating at all-ones (no wrap).
- Simultaneous events: ecall beats tohost store, which beats timeout. An event in the same cycle as the timeout threshold resolves as the event, not TIMEOUT.
- Latency:
  - Event sampled at edge N.
  - done/pass/fail/timeout high from after edge N.
  - done_pulse high for exactly the cycle following edge N.
  - cycle_count on the terminating edge is not incremented; it equals the number of non-terminating RUN cycles.
- Terminal states (PASS/FAIL/TIMEOUT):
  - Hold all outputs; later ecalls and stores are ignored (the first event wins).
  - start -> RUN with all status outputs cleared on the same edge.
- Exactly one of pass/fail/timeout is high whenever done=1; all are 0 otherwise.
- rst asserted mid-RUN or in a terminal state returns to IDLE immediately; no status is retained.
- TIMEOUT_CYCLES=1: the first RUN cycle with no event times out, cycle_count=0.

Test Plan:
- Ecall pass: rst, then start; 20 idle cycles; is_ecall=1 with gp_value=1 -> pass=1, done=1, fail_code=0, cycle_count=20, done_pulse high for 1 cycle.
- Ecall fail: start; after 7 cycles is_ecall=1 with gp_value=32'h0000_0007 -> fail=1, fail_code=3, pass=0, cycle_count=7.
- Tohost, with TOHOST_ADDR=32'h1000:
  - store_valid to 32'h1000 with data 0 -> stays RUN.
  - Next store with data 32'h0000_000B -> fail=1, fail_code=5.
  - A store to 32'h1004 with data 1 is ignored.
- Timeout with TIMEOUT_CYCLES=50: start, no events -> timeout=1 after exactly 50 edges in RUN, cycle_count=49. An ecall with gp=1 on the 50th edge -> pass=1 instead of timeout.
- Priority and sticky:
  - is_ecall with gp=1 in the same cycle as a tohost store of data 5 -> pass.
  - A subsequent is_ecall with gp=9 leaves pass=1, fail_code=0.
  - start -> all status 0, RUN, cycle_count restarts at 0.
- Async reset: assert rst mid-RUN between clock edges -> all outputs 0 immediately. An ecall while in IDLE after reset release -> no status change.
